// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller shared by instruction fetch and MEM-stage loads/stores.
// Reads finish N+1 edges after acceptance and writes after N; rdy low stalls every register.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_inst,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [1:0]  mem_len,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   input  logic [7:0]  ram_din,
   output logic [7:0]  ram_dout,
   output logic [31:0] ram_a,
   output logic        ram_wr
);
   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic [2:0]  nbytes, nbytes_nxt;
   logic        is_fetch, is_fetch_nxt;
   logic [31:0] base, base_nxt;
   logic [31:0] wdata, wdata_nxt;
   logic [31:0] rbuf, rbuf_nxt;
   logic [31:0] ram_a_nxt, if_inst_nxt, mem_rdata_nxt;
   logic [7:0]  ram_dout_nxt;
   logic        ram_wr_nxt, if_done_nxt, mem_done_nxt;
   logic        accept;
   logic [2:0]  mem_nbytes;
   logic [31:0] cur_addr;

   // The edge that carries a done pulse is never an acceptance edge.
   assign accept   = (state == IDLE) && !if_done && !mem_done && (mem_req || if_req);
   assign cur_addr = base + {29'd0, cnt};

   always_comb begin
      case (mem_len)
         2'd0:    mem_nbytes = 3'd1;
         2'd1:    mem_nbytes = 3'd2;
         default: mem_nbytes = 3'd4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else if (rdy)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (mem_req && mem_we) ? WRITE : READ;
         READ:    if (cnt == nbytes + 3'd1) state_nxt = IDLE;
         WRITE:   if (cnt == nbytes) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt       = cnt;
      nbytes_nxt    = nbytes;
      is_fetch_nxt  = is_fetch;
      base_nxt      = base;
      wdata_nxt     = wdata;
      rbuf_nxt      = rbuf;
      ram_a_nxt     = ram_a;
      ram_dout_nxt  = ram_dout;
      ram_wr_nxt    = 1'b0;
      if_inst_nxt   = if_inst;
      mem_rdata_nxt = mem_rdata;
      if_done_nxt   = 1'b0;
      mem_done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = 3'd0;
            if (accept) begin
               cnt_nxt      = 3'd1;
               is_fetch_nxt = !mem_req;
               nbytes_nxt   = mem_req ? mem_nbytes : 3'd4;
               base_nxt     = mem_req ? mem_addr : if_addr;
               ram_a_nxt    = mem_req ? mem_addr : if_addr;
               wdata_nxt    = mem_wdata;
               rbuf_nxt     = 32'd0;
               if (mem_req && mem_we) begin
                  ram_wr_nxt   = 1'b1;
                  ram_dout_nxt = mem_wdata[7:0];
               end
            end
         end
         READ: begin
            cnt_nxt = cnt + 3'd1;
            if (cnt < nbytes)
               ram_a_nxt = cur_addr;
            // RAM data lags its address by two edges, so byte i lands at edge i+2.
            case (cnt)
               3'd2:    rbuf_nxt[7:0]   = ram_din;
               3'd3:    rbuf_nxt[15:8]  = ram_din;
               3'd4:    rbuf_nxt[23:16] = ram_din;
               3'd5:    rbuf_nxt[31:24] = ram_din;
               default: ;
            endcase
            if (cnt == nbytes + 3'd1) begin
               cnt_nxt = 3'd0;
               if (is_fetch) begin
                  if_inst_nxt = rbuf_nxt;
                  if_done_nxt = 1'b1;
               end else begin
                  mem_rdata_nxt = rbuf_nxt;
                  mem_done_nxt  = 1'b1;
               end
            end
         end
         WRITE: begin
            if (cnt < nbytes) begin
               cnt_nxt    = cnt + 3'd1;
               ram_a_nxt  = cur_addr;
               ram_wr_nxt = 1'b1;
               case (cnt[1:0])
                  2'd0:    ram_dout_nxt = wdata[7:0];
                  2'd1:    ram_dout_nxt = wdata[15:8];
                  2'd2:    ram_dout_nxt = wdata[23:16];
                  default: ram_dout_nxt = wdata[31:24];
               endcase
            end else begin
               cnt_nxt      = 3'd0;
               mem_done_nxt = 1'b1;
            end
         end
         default: cnt_nxt = 3'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= 3'd0;
         nbytes    <= 3'd0;
         is_fetch  <= 1'b0;
         base      <= 32'd0;
         wdata     <= 32'd0;
         rbuf      <= 32'd0;
         ram_a     <= 32'd0;
         ram_dout  <= 8'd0;
         ram_wr    <= 1'b0;
         if_inst   <= 32'd0;
         mem_rdata <= 32'd0;
         if_done   <= 1'b0;
         mem_done  <= 1'b0;
      end else if (rdy) begin
         cnt       <= cnt_nxt;
         nbytes    <= nbytes_nxt;
         is_fetch  <= is_fetch_nxt;
         base      <= base_nxt;
         wdata     <= wdata_nxt;
         rbuf      <= rbuf_nxt;
         ram_a     <= ram_a_nxt;
         ram_dout  <= ram_dout_nxt;
         ram_wr    <= ram_wr_nxt;
         if_inst   <= if_inst_nxt;
         mem_rdata <= mem_rdata_nxt;
         if_done   <= if_done_nxt;
         mem_done  <= mem_done_nxt;
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl: a byte-array RAM plus a per-access reference model
// that predicts address sequence, write bytes, done timing and returned data.
module tb_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        if_req, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [1:0]  mem_len;
   logic        if_done, mem_done, ram_wr;
   logic [31:0] if_inst, mem_rdata, ram_a;
   logic [7:0]  ram_din, ram_dout;

   logic [7:0]  ram     [0:4095];
   logic [7:0]  ref_ram [0:4095];
   logic [31:0] last_if_inst, last_mem_rdata;
   int          checks = 0;
   int          errors = 0;

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
   );

   always #5 clk = ~clk;

   // Synchronous RAM that stalls together with the controller.
   always @(posedge clk) begin
      if (rdy) begin
         ram_din <= ram[ram_a[11:0]];
         if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
      ram[a[11:0]]     = v;
      ref_ram[a[11:0]] = v;
   endtask

   // Called right after a negedge while the controller is idle and able to accept.
   task automatic run_access(input bit is_mem, input bit we, input logic [1:0] len,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int stall_at, input int stall_len, input string name);
      int n, done_k, k, edges, stall_cnt;
      bit act, done_seen;
      logic [31:0] exp_a, exp_data, t;
      logic [106:0] prev, cur;
      n = !is_mem ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
      done_k = (is_mem && we) ? n : n + 1;
      exp_data = 32'd0;
      for (int i = 0; i < n; i++) begin
         t = addr + 32'(i);
         exp_data[8*i +: 8] = ref_ram[t[11:0]];
      end
      if (is_mem) begin
         mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      rdy = 1'b1;
      k = -1; edges = 0; stall_cnt = 0; done_seen = 1'b0;
      prev = {ram_a, ram_wr, ram_dout, if_done, mem_done, if_inst, mem_rdata};
      while (!done_seen && edges < 40) begin
         @(posedge clk);
         act = rdy;
         edges++;
         if (act) k++;
         @(negedge clk);
         cur = {ram_a, ram_wr, ram_dout, if_done, mem_done, if_inst, mem_rdata};
         if (!act) begin
            checks++;
            if (cur !== prev) begin
               errors++;
               $display("FAIL %s frozen k=%0d got %h exp %h", name, k, cur, prev);
            end
         end else begin
            if (k < n) begin
               exp_a = addr + 32'(k);
               checks++;
               if (ram_a !== exp_a) begin
                  errors++;
                  $display("FAIL %s ram_a k=%0d got %h exp %h", name, k, ram_a, exp_a);
               end
               checks++;
               if (ram_wr !== (is_mem && we)) begin
                  errors++;
                  $display("FAIL %s ram_wr k=%0d got %b exp %b", name, k, ram_wr, is_mem && we);
               end
               if (is_mem && we) begin
                  checks++;
                  if (ram_dout !== wdata[8*k +: 8]) begin
                     errors++;
                     $display("FAIL %s ram_dout k=%0d got %h exp %h", name, k, ram_dout, wdata[8*k +: 8]);
                  end
               end
            end
            if (k == 0) begin
               if (is_mem) begin
                  mem_addr = $urandom; mem_wdata = $urandom;
                  mem_len = 2'($urandom_range(0, 3)); mem_we = 1'($urandom_range(0, 1));
               end else begin
                  if_addr = $urandom;
               end
            end
            if (k < done_k) begin
               checks++;
               if ({if_done, mem_done} !== 2'b00) begin
                  errors++;
                  $display("FAIL %s early_done k=%0d got %b exp 00", name, k, {if_done, mem_done});
               end
            end else begin
               done_seen = 1'b1;
               checks++;
               if ({if_done, mem_done} !== (is_mem ? 2'b01 : 2'b10)) begin
                  errors++;
                  $display("FAIL %s done k=%0d got %b exp %b", name, k, {if_done, mem_done},
                           is_mem ? 2'b01 : 2'b10);
               end
               if (is_mem && we) begin
                  checks++;
                  if (ram_wr !== 1'b0) begin
                     errors++;
                     $display("FAIL %s ram_wr_end got %b exp 0", name, ram_wr);
                  end
               end else if (is_mem) begin
                  checks++;
                  if (mem_rdata !== exp_data) begin
                     errors++;
                     $display("FAIL %s mem_rdata got %h exp %h", name, mem_rdata, exp_data);
                  end
                  checks++;
                  if (if_inst !== last_if_inst) begin
                     errors++;
                     $display("FAIL %s if_inst_hold got %h exp %h", name, if_inst, last_if_inst);
                  end
               end else begin
                  checks++;
                  if (if_inst !== exp_data) begin
                     errors++;
                     $display("FAIL %s if_inst got %h exp %h", name, if_inst, exp_data);
                  end
                  checks++;
                  if (mem_rdata !== last_mem_rdata) begin
                     errors++;
                     $display("FAIL %s mem_rdata_hold got %h exp %h", name, mem_rdata, last_mem_rdata);
                  end
               end
            end
         end
         prev = cur;
         if (k == stall_at && stall_cnt < stall_len) begin
            rdy = 1'b0;
            stall_cnt++;
         end else begin
            rdy = 1'b1;
         end
      end
      if (!done_seen) begin
         checks++;
         errors++;
         $display("FAIL %s timeout got no done exp done at k=%0d", name, done_k);
      end
      if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
      rdy = 1'b1;
      if (is_mem && we) begin
         for (int i = 0; i < n; i++) begin
            t = addr + 32'(i);
            ref_ram[t[11:0]] = wdata[8*i +: 8];
         end
      end else if (is_mem) begin
         last_mem_rdata = exp_data;
      end else begin
         last_if_inst = exp_data;
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({if_done, mem_done, ram_wr} !== 3'b000) begin
         errors++;
         $display("FAIL %s idle got %b exp 000", name, {if_done, mem_done, ram_wr});
      end
      checks++;
      if (if_inst !== last_if_inst || mem_rdata !== last_mem_rdata) begin
         errors++;
         $display("FAIL %s data_hold got %h/%h exp %h/%h", name, if_inst, mem_rdata,
                  last_if_inst, last_mem_rdata);
      end
      if (is_mem && we) begin
         for (int i = 0; i < n; i++) begin
            t = addr + 32'(i);
            checks++;
            if (ram[t[11:0]] !== ref_ram[t[11:0]]) begin
               errors++;
               $display("FAIL %s ram_content a=%h got %h exp %h", name, t, ram[t[11:0]], ref_ram[t[11:0]]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ram_a, ram_dout, ram_wr, if_done, mem_done} !== 43'd0) begin
         errors++;
         $display("FAIL reset_ctrl got %h exp 0", {ram_a, ram_dout, ram_wr, if_done, mem_done});
      end
      checks++;
      if ({if_inst, mem_rdata} !== 64'd0) begin
         errors++;
         $display("FAIL reset_data got %h exp 0", {if_inst, mem_rdata});
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ram_a, ram_wr, if_done, mem_done} !== 35'd0) begin
         errors++;
         $display("FAIL reset_idle got %h exp 0", {ram_a, ram_wr, if_done, mem_done});
      end
      last_if_inst = 32'd0;
      last_mem_rdata = 32'd0;
   endtask

   task automatic test_fetch();
      set_byte(32'h100, 8'h13); set_byte(32'h101, 8'h00);
      set_byte(32'h102, 8'h50); set_byte(32'h103, 8'h00);
      run_access(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, -1, 0, "fetch");
      checks++;
      if (if_inst !== 32'h00500013) begin
         errors++;
         $display("FAIL fetch_word got %h exp 00500013", if_inst);
      end
   endtask

   task automatic test_byte_load();
      set_byte(32'h203, 8'hF5);
      run_access(1'b1, 1'b0, 2'd0, 32'h203, 32'd0, -1, 0, "byte_load");
      checks++;
      if (mem_rdata !== 32'h000000F5) begin
         errors++;
         $display("FAIL byte_load_val got %h exp 000000f5", mem_rdata);
      end
   endtask

   task automatic test_word_store();
      run_access(1'b1, 1'b1, 2'd2, 32'h400, 32'hDEADBEEF, -1, 0, "word_store");
      checks++;
      if ({ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]} !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL word_store_ram got %h exp deadbeef",
                  {ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]});
      end
   endtask

   task automatic test_arbitration();
      if_req = 1'b1;
      if_addr = 32'h104;
      run_access(1'b1, 1'b0, 2'd2, 32'h500, 32'd0, -1, 0, "arb_mem");
      checks++;
      if (ram_a !== 32'h503 || if_done !== 1'b0) begin
         errors++;
         $display("FAIL arb_idle got ram_a=%h if_done=%b exp ram_a=503 if_done=0", ram_a, if_done);
      end
      run_access(1'b0, 1'b0, 2'd2, 32'h104, 32'd0, -1, 0, "arb_fetch");
   endtask

   task automatic test_stall();
      run_access(1'b1, 1'b0, 2'd2, 32'h600, 32'd0, 2, 3, "stall_load");
      run_access(1'b1, 1'b1, 2'd1, 32'h610, 32'h0000A5C3, 0, 2, "stall_store");
   endtask

   task automatic test_reset_mid_store();
      mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
      mem_addr = 32'h700; mem_wdata = 32'h11223344;
      rdy = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (ram_wr !== 1'b1 || ram_a !== 32'h701) begin
         errors++;
         $display("FAIL rst_store_pre got wr=%b a=%h exp wr=1 a=701", ram_wr, ram_a);
      end
      rst = 1'b1;
      rdy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rdy = 1'b1;
      mem_req = 1'b0;
      checks++;
      if ({ram_wr, mem_done, ram_a, mem_rdata, if_inst} !== 98'd0) begin
         errors++;
         $display("FAIL rst_store got %h exp 0", {ram_wr, mem_done, ram_a, mem_rdata, if_inst});
      end
      ref_ram[12'h700] = 8'h44;
      last_if_inst = 32'd0;
      last_mem_rdata = 32'd0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({ram_wr, mem_done, if_done, ram_a} !== 35'd0) begin
            errors++;
            $display("FAIL rst_store_idle got %h exp 0", {ram_wr, mem_done, if_done, ram_a});
         end
      end
      run_access(1'b1, 1'b0, 2'd2, 32'h700, 32'd0, -1, 0, "rst_after_load");
   endtask

   task automatic test_wrap();
      run_access(1'b1, 1'b0, 2'd2, 32'hFFFFFFFE, 32'd0, -1, 0, "wrap_load");
      run_access(1'b0, 1'b0, 2'd0, 32'hFFFFFFFF, 32'd0, 1, 1, "wrap_fetch");
   endtask

   task automatic test_random();
      bit is_mem, we;
      for (int it = 0; it < 40; it++) begin
         is_mem = ($urandom_range(0, 2) != 0);
         we = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
         run_access(is_mem, we, 2'($urandom_range(0, 3)), $urandom, $urandom,
                    $urandom_range(0, 7), $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1;
      if_req = 1'b0; if_addr = 32'd0;
      mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
      last_if_inst = 32'd0; last_mem_rdata = 32'd0;
      for (int i = 0; i < 4096; i++) begin
         ram[i] = 8'($urandom);
         ref_ram[i] = ram[i];
      end
      test_reset();
      test_fetch();
      test_byte_load();
      test_word_store();
      test_arbitration();
      test_stall();
      test_reset_mid_store();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
